// File: rtl/normalizer.sv
// Multicycle 16-bit normalize unit: binary-search leading/trailing zero count
// (8, 4, 2, 1 per cycle) with a start/done handshake and registered results.
module normalizer (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] In,
  input  logic        Dir,
  output logic [15:0] Out,
  output logic [3:0]  Cnt,
  output logic        Zero,
  output logic        busy,
  output logic        done
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    S8   = 3'd1,
    S4   = 3'd2,
    S2   = 3'd3,
    S1   = 3'd4,
    DONE = 3'd5
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] work_q, work_d;
  logic [3:0]  acc_q, acc_d;
  logic        dir_q;
  logic [15:0] out_q;
  logic [3:0]  cnt_q;
  logic        zero_q;
  logic        busy_q;
  logic        done_q;
  logic        accept;

  // Dir 0 tests the top k bits and shifts left; Dir 1 tests the bottom k
  // bits and shifts right. A stage that fires sets its count bit.
  always_comb begin
    work_d  = work_q;
    acc_d   = acc_q;
    state_d = state_q;
    accept  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          accept  = 1'b1;
          state_d = S8;
        end
      end
      S8: begin
        state_d = S4;
        if (!dir_q && work_q[15:8] == 8'h00) begin
          work_d   = work_q << 8;
          acc_d[3] = 1'b1;
        end else if (dir_q && work_q[7:0] == 8'h00) begin
          work_d   = work_q >> 8;
          acc_d[3] = 1'b1;
        end
      end
      S4: begin
        state_d = S2;
        if (!dir_q && work_q[15:12] == 4'h0) begin
          work_d   = work_q << 4;
          acc_d[2] = 1'b1;
        end else if (dir_q && work_q[3:0] == 4'h0) begin
          work_d   = work_q >> 4;
          acc_d[2] = 1'b1;
        end
      end
      S2: begin
        state_d = S1;
        if (!dir_q && work_q[15:14] == 2'b00) begin
          work_d   = work_q << 2;
          acc_d[1] = 1'b1;
        end else if (dir_q && work_q[1:0] == 2'b00) begin
          work_d   = work_q >> 2;
          acc_d[1] = 1'b1;
        end
      end
      S1: begin
        state_d = DONE;
        if (!dir_q && !work_q[15]) begin
          work_d   = work_q << 1;
          acc_d[0] = 1'b1;
        end else if (dir_q && !work_q[0]) begin
          work_d   = work_q >> 1;
          acc_d[0] = 1'b1;
        end
      end
      DONE: begin
        if (start) begin
          accept  = 1'b1;
          state_d = S8;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      work_q  <= 16'h0000;
      acc_q   <= 4'h0;
      dir_q   <= 1'b0;
      out_q   <= 16'h0000;
      cnt_q   <= 4'h0;
      zero_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q  <= (state_d == S8) || (state_d == S4) ||
                 (state_d == S2) || (state_d == S1);
      done_q  <= (state_d == DONE);
      if (accept) begin
        work_q <= In;
        dir_q  <= Dir;
        acc_q  <= 4'h0;
      end else begin
        work_q <= work_d;
        acc_q  <= acc_d;
      end
      // A nonzero operand can never shift to zero, so a zero final work
      // word identifies a zero operand.
      if (state_q == S1) begin
        out_q  <= work_d;
        cnt_q  <= acc_d;
        zero_q <= (work_d == 16'h0000);
      end
    end
  end

  assign Out  = out_q;
  assign Cnt  = cnt_q;
  assign Zero = zero_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_normalizer.sv
// Directed and swept checks of the normalizer against hand values and a
// shift-count reference model.
module tb_normalizer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] In;
  logic        Dir;
  logic [15:0] Out;
  logic [3:0]  Cnt;
  logic        Zero;
  logic        busy;
  logic        done;

  int nvec  = 0;
  int nmiss = 0;

  normalizer dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .In    (In),
    .Dir   (Dir),
    .Out   (Out),
    .Cnt   (Cnt),
    .Zero  (Zero),
    .busy  (busy),
    .done  (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    if (obs !== exp) begin
      nmiss++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Waits for done after the accept edge; lat is the number of edges taken.
  task automatic wait_done(output int lat);
    lat = 0;
    while (done !== 1'b1 && lat < 12) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic run_op(input logic [15:0] a, input logic d, output int lat);
    @(negedge clk);
    start = 1'b1; In = a; Dir = d;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(lat);
  endtask

  task automatic op_check(input string tag, input logic [15:0] a, input logic d,
                          input logic [15:0] eout, input logic [3:0] ecnt, input logic ezero);
    int lat;
    run_op(a, d, lat);
    check({tag, "_lat"}, lat, 4);
    check({tag, "_out"}, Out, eout);
    check({tag, "_cnt"}, Cnt, ecnt);
    check({tag, "_zero"}, Zero, ezero);
  endtask

  function automatic logic [3:0] ref_cnt(input logic [15:0] a, input logic d);
    int n;
    if (a == 16'h0000) return 4'hF;
    n = 0;
    if (!d) begin
      for (int i = 15; i >= 0; i--) begin
        if (a[i]) break;
        n++;
      end
    end else begin
      for (int i = 0; i < 16; i++) begin
        if (a[i]) break;
        n++;
      end
    end
    return n[3:0];
  endfunction

  function automatic logic [15:0] barrel(input logic [15:0] a, input logic [3:0] c, input logic d);
    return d ? (a >> c) : (a << c);
  endfunction

  initial begin
    int lat;
    logic [15:0] a;
    logic        d;
    logic [3:0]  ec;
    rst = 1'b1; start = 1'b0; In = 16'h0000; Dir = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out", Out, 16'h0000);
    check("rst_cnt", Cnt, 4'h0);
    check("rst_zero", Zero, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    op_check("one_l",   16'h0001, 1'b0, 16'h8000, 4'hF, 1'b0);
    op_check("x1234_l", 16'h1234, 1'b0, 16'h91A0, 4'h3, 1'b0);
    op_check("x1234_r", 16'h1234, 1'b1, 16'h048D, 4'h2, 1'b0);
    op_check("zero_l",  16'h0000, 1'b0, 16'h0000, 4'hF, 1'b1);
    op_check("zero_r",  16'h0000, 1'b1, 16'h0000, 4'hF, 1'b1);
    op_check("norm_l",  16'h8000, 1'b0, 16'h8000, 4'h0, 1'b0);
    op_check("norm_r",  16'h0001, 1'b1, 16'h0001, 4'h0, 1'b0);
    op_check("top_r",   16'h8000, 1'b1, 16'h0001, 4'hF, 1'b0);

    // Results hold through idle cycles.
    repeat (3) @(posedge clk);
    #1;
    check("hold_out", Out, 16'h0001);
    check("hold_cnt", Cnt, 4'hF);
    check("hold_done", done, 1'b0);

    // start during S4 is ignored.
    @(negedge clk);
    start = 1'b1; In = 16'h00F0; Dir = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    check("ign_busy_s8", busy, 1'b1);
    @(posedge clk); #1;
    start = 1'b1; In = 16'hFFFF;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(lat);
    check("ign_lat", lat + 2, 4);
    check("ign_out", Out, 16'hF000);
    check("ign_cnt", Cnt, 4'h8);

    // Back-to-back accept from DONE with start held high.
    start = 1'b1; In = 16'h0030; Dir = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("b2b_busy", busy, 1'b1);
    check("b2b_done", done, 1'b0);
    wait_done(lat);
    check("b2b_lat", lat, 4);
    check("b2b_out", Out, 16'h0003);
    check("b2b_cnt", Cnt, 4'h4);

    // Reset in S2 aborts.
    @(negedge clk);
    start = 1'b1; In = 16'h0001; Dir = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("abort_in_s2", busy, 1'b1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort_busy", busy, 1'b0);
    check("abort_done", done, 1'b0);
    check("abort_out", Out, 16'h0000);
    check("abort_cnt", Cnt, 4'h0);
    check("abort_zero", Zero, 1'b0);
    lat = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (done === 1'b1) lat++;
    end
    check("abort_no_done", lat, 0);

    // Sweep against the reference count and barrel shifter.
    for (int i = 0; i < 10000; i++) begin
      a = 16'($urandom);
      if (i % 7 == 0) a = a >> (i % 16);
      if (i % 11 == 0) a = a << (i % 16);
      if (i == 5000) a = 16'h0000;
      d = i[0];
      ec = ref_cnt(a, d);
      run_op(a, d, lat);
      check($sformatf("sw_lat_%04h_%0d", a, d), lat, 4);
      check($sformatf("sw_cnt_%04h_%0d", a, d), Cnt, ec);
      check($sformatf("sw_out_%04h_%0d", a, d), Out, (a == 16'h0000) ? 16'h0000 : barrel(a, Cnt, d));
      check($sformatf("sw_ref_%04h_%0d", a, d), Out, (a == 16'h0000) ? 16'h0000 : barrel(a, ec, d));
      check($sformatf("sw_zero_%04h_%0d", a, d), Zero, (a == 16'h0000));
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmiss);
    $finish;
  end

endmodule
